// File: rtl/mm_seq_ctrl.sv
// Step sequencer for one systolic matrix-multiply pass: clear, feed k_len steps, drain 2N-1 cycles, done.
// Optional abort port pair is enabled by defining MM_SEQ_ABORT_EN.
module mm_seq_ctrl #(
  parameter int ARRAY_DIM = 8,
  parameter int KLEN_W    = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
`ifdef MM_SEQ_ABORT_EN
  input  logic              abort_i,
  output logic              aborted_o,
`endif
  input  logic              start_i,
  input  logic [KLEN_W-1:0] k_len_i,
  input  logic              stall_i,
  output logic              acc_clr_o,
  output logic              feed_en_o,
  output logic              drain_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [KLEN_W-1:0] step_cnt_o
);

  localparam int DRAIN_LEN = 2 * ARRAY_DIM - 1;
  localparam int DCW       = $clog2(2 * ARRAY_DIM);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [KLEN_W-1:0] klen_q, klen_d;
  logic [KLEN_W-1:0] step_q, step_d;
  logic [DCW-1:0]    dcnt_q, dcnt_d;
  logic              acc_clr_q, acc_clr_d;
  logic              feed_q, feed_d;
  logic              drain_q, drain_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [KLEN_W-1:0] steps_after;
  logic [DCW-1:0]    drains_after;
`ifdef MM_SEQ_ABORT_EN
  logic              aborted_q, aborted_d;
`endif

  // feed_q/drain_q mark whether the current cycle is a real step; a stall only
  // suppresses the next step, and a stalled final step keeps the state parked.
  assign steps_after  = step_q + KLEN_W'(feed_q);
  assign drains_after = dcnt_q + DCW'(drain_q);

  always_comb begin
    state_d   = state_q;
    klen_d    = klen_q;
    step_d    = step_q;
    dcnt_d    = dcnt_q;
    acc_clr_d = 1'b0;
    feed_d    = 1'b0;
    drain_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef MM_SEQ_ABORT_EN
    aborted_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          klen_d = k_len_i;
          step_d = '0;
          if (k_len_i != '0) begin
            state_d   = CLEAR;
            acc_clr_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = FEED;
        feed_d  = 1'b1;
        busy_d  = 1'b1;
        dcnt_d  = '0;
      end
      FEED: begin
        busy_d = 1'b1;
        step_d = steps_after;
        if (steps_after == klen_q) begin
          if (!stall_i) begin
            state_d = DRAIN;
            drain_d = 1'b1;
          end
        end else begin
          feed_d = !stall_i;
        end
      end
      DRAIN: begin
        busy_d = 1'b1;
        dcnt_d = drains_after;
        if (drains_after == DCW'(DRAIN_LEN)) begin
          if (!stall_i) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          drain_d = !stall_i;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef MM_SEQ_ABORT_EN
    // Abort wins over stall and over any completion decided above.
    if (abort_i && (state_q == CLEAR || state_q == FEED || state_q == DRAIN)) begin
      state_d   = IDLE;
      step_d    = step_q;
      dcnt_d    = dcnt_q;
      acc_clr_d = 1'b0;
      feed_d    = 1'b0;
      drain_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      klen_q    <= '0;
      step_q    <= '0;
      dcnt_q    <= '0;
      acc_clr_q <= 1'b0;
      feed_q    <= 1'b0;
      drain_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MM_SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      klen_q    <= klen_d;
      step_q    <= step_d;
      dcnt_q    <= dcnt_d;
      acc_clr_q <= acc_clr_d;
      feed_q    <= feed_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MM_SEQ_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign acc_clr_o  = acc_clr_q;
  assign feed_en_o  = feed_q;
  assign drain_o    = drain_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign step_cnt_o = step_q;
`ifdef MM_SEQ_ABORT_EN
  assign aborted_o  = aborted_q;
`endif

  // The downstream enable gate relies on feed and drain being exclusive.
  a_feed_drain_excl : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(feed_q && drain_q));
  a_done_not_busy : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(done_q && busy_q));
  a_done_one_cycle : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    done_q |=> !done_q);

endmodule
